// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM feeding a small
// in-order instruction queue toward decode, with redirect flush.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [PW:0]   count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

    logic          push;
    logic          pop;
    logic          can_issue;
    logic [31:0]   target;
    logic          unused_bits;

    assign target      = {redirect_pc[31:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];
    assign pop         = instr_valid && instr_ready;
    assign push        = (state == WAIT) && imem_rvalid && !redirect;
    // Only IDLE issues, and nothing is outstanding there.
    assign can_issue   = count < FULL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end else if (can_issue) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        imem_req <= 1'b0;
                        state    <= imem_gnt ? DRAIN : IDLE;
                    end else if (imem_gnt) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        state    <= imem_rvalid ? IDLE : DRAIN;
                    end else if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    // A response arriving with the redirect still retires it.
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // imem_addr is held from issue until the response, so it tags the word.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= imem_addr;
        end
    end

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr] : 32'h0;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a queue-based fetch model,
// plus directed scenarios for fill, redirect, stall, wrap and reset.
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;

    always #5 clk = ~clk;

    mips_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct(funct)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(w_rvalid),
        .imem_rdata(32'h1234_5678),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc),
        .opcode(w_opcode), .funct(w_funct)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];
    logic [31:0] next_pc;
    int   epoch = 0;
    logic pend;
    int   pend_epoch;
    logic [31:0] pend_pc;
    int   lat_cnt;
    logic hold;
    logic [31:0] hold_addr;
    int   ngnt;
    int   npop;
    logic [31:0] last_gnt;
    int   k_gnt, k_ready, k_redir, k_lmin, k_lmax;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // One cycle: check outputs against the model, drive inputs,
    // advance the model for the coming edge, then move to the next negedge.
    task automatic step(input logic fr, input logic [31:0] frpc);
        logic g_evt, r_evt, p_evt;
        int   rv_epoch;
        ent_t e;
        check("valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            e = mq[0];
            check("instr", instr, e.data);
            check("instr_pc", instr_pc, e.pc);
            check("opcode", {26'b0, opcode}, {26'b0, e.data[31:26]});
            check("funct", {26'b0, funct}, {26'b0, e.data[5:0]});
        end else begin
            check("instr_empty", instr, 32'h0);
            check("pc_empty", instr_pc, 32'h0);
        end
        if (pend) check("one_outstanding", {31'b0, imem_req}, 32'h0);
        if (hold) begin
            check("req_hold", {31'b0, imem_req}, 32'h1);
            check("addr_hold", imem_addr, hold_addr);
        end

        imem_gnt    = rnd(k_gnt);
        redirect    = fr || rnd(k_redir);
        redirect_pc = fr ? frpc : $urandom;
        instr_ready = rnd(k_ready);
        imem_rvalid = pend && (lat_cnt == 0);
        imem_rdata  = imem_rvalid ? word_of(pend_pc) : $urandom;

        g_evt     = imem_req && imem_gnt;
        r_evt     = imem_rvalid;
        p_evt     = instr_valid && instr_ready;
        hold      = imem_req && !imem_gnt && !redirect;
        hold_addr = imem_addr;
        rv_epoch  = pend_epoch;

        if (r_evt) pend = 1'b0;
        else if (pend && lat_cnt > 0) lat_cnt--;
        if (g_evt) begin
            check("gnt_addr", imem_addr, next_pc);
            pend       = 1'b1;
            pend_pc    = next_pc;
            pend_epoch = epoch;
            lat_cnt    = $urandom_range(k_lmin, k_lmax);
            next_pc    = next_pc + 32'd4;
            last_gnt   = imem_addr;
            ngnt++;
        end
        if (redirect) begin
            mq.delete();
            epoch++;
            next_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (p_evt && mq.size() != 0) begin
                void'(mq.pop_front());
                npop++;
            end
            if (r_evt && rv_epoch == epoch) begin
                e.pc   = pend_pc;
                e.data = imem_rdata;
                mq.push_back(e);
                check("qbound", {31'b0, mq.size() <= QDEPTH}, 32'h1);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fields", {20'b0, opcode, funct}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        mq.delete();
        epoch++;
        next_pc = RESET_PC;
        pend    = 1'b0;
        hold    = 1'b0;
        ngnt    = 0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("rst_first_req", {31'b0, imem_req}, 32'h1);
        check("rst_first_addr", imem_addr, RESET_PC);
    endtask

    task automatic knobs(input int g, input int r, input int d,
                         input int lmin, input int lmax);
        k_gnt   = g;
        k_ready = r;
        k_redir = d;
        k_lmin  = lmin;
        k_lmax  = lmax;
    endtask

    initial begin
        logic [31:0] got [3];
        int   n;
        logic w_out;
        logic seen;
        rst_n       = 1'b0;
        w_rst_n     = 1'b0;
        w_rvalid    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        pend        = 1'b0;
        pend_epoch  = 0;
        pend_pc     = 32'h0;
        lat_cnt     = 0;
        hold        = 1'b0;
        hold_addr   = 32'h0;
        next_pc     = RESET_PC;
        ngnt        = 0;
        npop        = 0;
        last_gnt    = 32'h0;
        knobs(100, 100, 0, 0, 0);

        // Sequential streaming
        do_reset();
        repeat (20) step(1'b0, 32'h0);
        check("stream_cnt", {31'b0, ngnt >= 5}, 32'h1);

        // Backpressure fills the queue
        knobs(100, 0, 0, 0, 0);
        do_reset();
        repeat (20) step(1'b0, 32'h0);
        check("fill_cnt", ngnt, 32'd2);
        check("fill_req_low", {31'b0, imem_req}, 32'h0);
        knobs(100, 100, 0, 0, 0);
        ngnt = 0;
        for (int i = 0; i < 10 && ngnt == 0; i++) step(1'b0, 32'h0);
        check("resume_addr", last_gnt, 32'h0000_0008);

        // Redirect while waiting on a response
        knobs(100, 100, 0, 2, 2);
        do_reset();
        for (int i = 0; i < 10 && !pend; i++) step(1'b0, 32'h0);
        check("redir_pend", {31'b0, pend}, 32'h1);
        step(1'b1, 32'h0000_0103);
        check("redir_flush", {31'b0, instr_valid}, 32'h0);
        ngnt = 0;
        for (int i = 0; i < 20 && ngnt == 0; i++) step(1'b0, 32'h0);
        check("redir_addr", last_gnt, 32'h0000_0100);

        // Grant withheld
        knobs(0, 100, 0, 0, 0);
        do_reset();
        repeat (5) step(1'b0, 32'h0);
        check("stall_req", {31'b0, imem_req}, 32'h1);
        check("stall_addr", imem_addr, RESET_PC);
        check("stall_nopush", {31'b0, instr_valid}, 32'h0);

        // Reset in the middle of a request
        knobs(100, 100, 0, 3, 3);
        do_reset();
        for (int i = 0; i < 10 && !pend; i++) step(1'b0, 32'h0);
        check("midrst_pend", {31'b0, pend}, 32'h1);
        do_reset();
        knobs(0, 100, 0, 0, 0);
        repeat (3) step(1'b0, 32'h0);

        // Address wrap on a second instance
        got[0] = 32'hBAD0_0BAD;
        got[1] = 32'hBAD0_0BAD;
        got[2] = 32'hBAD0_0BAD;
        n      = 0;
        w_out  = 1'b0;
        seen   = 1'b0;
        @(negedge clk);
        w_rst_n = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            w_rvalid = w_out;
            w_out    = 1'b0;
            if (w_valid && !seen) begin
                check("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFF8);
                seen = 1'b1;
            end
            if (w_req) begin
                got[n] = w_addr;
                n++;
                w_out = 1'b1;
            end
        end
        check("wrap_a0", got[0], 32'hFFFF_FFF8);
        check("wrap_a1", got[1], 32'hFFFF_FFFC);
        check("wrap_a2", got[2], 32'h0000_0000);

        // Random traffic
        knobs(60, 70, 8, 0, 3);
        do_reset();
        npop = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step(1'b0, 32'h0);
        end
        check("progress", {31'b0, npop > 100}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
